// File: rtl/dist_pkg.sv
// Shared types and width helpers for the distance engine (dist_unit, isqrt_seq).
package dist_pkg;

    typedef enum logic [1:0] {
        DIST_EUCLID    = 2'b00,
        DIST_MANHATTAN = 2'b01,
        DIST_CHEBYSHEV = 2'b10
    } dist_mode_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DIFF = 3'd1,
        SUM  = 3'd2,
        ROOT = 3'd3,
        DONE = 3'd4
    } dist_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/isqrt_seq.sv
// Sequential restoring square root: one root bit per cycle, MSB first, OW cycles.
// The first iteration runs on the start edge straight from the radicand input.
module isqrt_seq #(
    parameter int SW = 23,
    parameter int OW = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [SW-1:0] radicand,
    output logic          busy,
    output logic          done,
    output logic [OW-1:0] root
);

    localparam int DW = 2 * OW;
    localparam int RW = OW + 3;
    localparam int CW = $clog2(OW + 1);

    logic [DW-1:0] data_reg;
    logic [RW-1:0] rem_reg;
    logic [OW-1:0] root_reg;
    logic [CW-1:0] count_reg;
    logic          busy_reg;
    logic          done_reg;

    logic [DW-1:0] data_in;
    logic [RW-1:0] rem_in;
    logic [OW-1:0] root_in;
    logic [RW-1:0] rem_shift;
    logic [RW-1:0] trial;
    logic [RW-1:0] rem_next;
    logic [OW-1:0] root_next;

    // A fresh start overrides any iteration in progress.
    always_comb begin
        data_in = data_reg;
        rem_in  = rem_reg;
        root_in = root_reg;
        if (start) begin
            data_in = DW'(radicand);
            rem_in  = '0;
            root_in = '0;
        end
        rem_shift = {rem_in[RW-3:0], data_in[DW-1 -: 2]};
        trial     = RW'({root_in, 2'b01});
        if (rem_shift >= trial) begin
            rem_next  = rem_shift - trial;
            root_next = {root_in[OW-2:0], 1'b1};
        end else begin
            rem_next  = rem_shift;
            root_next = {root_in[OW-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_reg  <= '0;
            rem_reg   <= '0;
            root_reg  <= '0;
            count_reg <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                data_reg  <= data_in << 2;
                rem_reg   <= rem_next;
                root_reg  <= root_next;
                count_reg <= CW'(OW - 1);
                busy_reg  <= 1'b1;
            end else if (busy_reg) begin
                data_reg  <= data_reg << 2;
                rem_reg   <= rem_next;
                root_reg  <= root_next;
                count_reg <= count_reg - CW'(1);
                if (count_reg == CW'(1)) begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign root = root_reg;

endmodule

// File: rtl/dist_unit.sv
// Handshaked 2-D distance engine (Euclidean / Manhattan / Chebyshev).
// Define DIST_ALT_METRIC_EN to build the Manhattan and Chebyshev metrics; otherwise all requests are Euclidean.
module dist_unit
    import dist_pkg::*;
#(
    parameter int XW = 11,
    parameter int YW = 10
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [XW-1:0]                  x_start,
    input  logic [XW-1:0]                  x_end,
    input  logic [YW-1:0]                  y_start,
    input  logic [YW-1:0]                  y_end,
    input  logic [1:0]                     mode,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [max_int(XW, YW):0]       distance,
    output logic [2*max_int(XW, YW):0]     sum_sqrs
);

    localparam int MW = max_int(XW, YW);
    localparam int SW = 2 * MW + 1;
    localparam int OW = MW + 1;

    dist_state_t state_reg, state_next;

    logic [XW-1:0] xs_reg, xe_reg;
    logic [YW-1:0] ys_reg, ye_reg;
    logic [MW-1:0] dx_reg, dy_reg;
    logic [SW-1:0] sum_hold_reg;
    logic [OW-1:0] distance_reg;
    logic [SW-1:0] sum_sqrs_reg;

    logic          accept;
    logic          is_euclid;
    logic          root_start;
    logic          root_busy;
    logic          root_done;
    logic [OW-1:0] root_value;
    logic [SW-1:0] dx_w, dy_w, sq;

`ifdef DIST_ALT_METRIC_EN
    logic [1:0]    mode_reg;
    logic [OW-1:0] alt_value;
    logic          unused_bits;

    assign is_euclid   = !(mode_reg == DIST_MANHATTAN || mode_reg == DIST_CHEBYSHEV);
    assign alt_value   = (mode_reg == DIST_MANHATTAN) ? (OW'(dx_reg) + OW'(dy_reg))
                                                      : OW'((dx_reg >= dy_reg) ? dx_reg : dy_reg);
    assign unused_bits = root_busy;
`else
    logic unused_bits;

    assign is_euclid   = 1'b1;
    assign unused_bits = ^{mode, root_busy};
`endif

    assign accept = in_valid && in_ready;
    assign dx_w   = SW'(dx_reg);
    assign dy_w   = SW'(dy_reg);
    assign sq     = dx_w * dx_w + dy_w * dy_w;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = DIFF;
            DIFF:    state_next = SUM;
            SUM:     state_next = is_euclid ? ROOT : DONE;
            ROOT:    if (root_done) state_next = DONE;
            DONE:    if (out_ready) state_next = accept ? DIFF : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (state_reg == IDLE) || (state_reg == DONE && out_ready);
        out_valid  = (state_reg == DONE);
        root_start = (state_reg == SUM) && is_euclid;
    end

    // Published results are written only on the transition into DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xs_reg       <= '0;
            xe_reg       <= '0;
            ys_reg       <= '0;
            ye_reg       <= '0;
            dx_reg       <= '0;
            dy_reg       <= '0;
            sum_hold_reg <= '0;
            distance_reg <= '0;
            sum_sqrs_reg <= '0;
`ifdef DIST_ALT_METRIC_EN
            mode_reg     <= 2'b00;
`endif
        end else begin
            if (accept) begin
                xs_reg <= x_start;
                xe_reg <= x_end;
                ys_reg <= y_start;
                ye_reg <= y_end;
`ifdef DIST_ALT_METRIC_EN
                mode_reg <= mode;
`endif
            end
            if (state_reg == DIFF) begin
                dx_reg <= (xs_reg >= xe_reg) ? MW'(xs_reg - xe_reg) : MW'(xe_reg - xs_reg);
                dy_reg <= (ys_reg >= ye_reg) ? MW'(ys_reg - ye_reg) : MW'(ye_reg - ys_reg);
            end
            if (state_reg == SUM) begin
                sum_hold_reg <= sq;
`ifdef DIST_ALT_METRIC_EN
                if (!is_euclid) begin
                    distance_reg <= alt_value;
                    sum_sqrs_reg <= '0;
                end
`endif
            end
            if (state_reg == ROOT && root_done) begin
                distance_reg <= root_value;
                sum_sqrs_reg <= sum_hold_reg;
            end
        end
    end

    isqrt_seq #(
        .SW (SW),
        .OW (OW)
    ) u_isqrt (
        .clk      (clk),
        .reset    (reset),
        .start    (root_start),
        .radicand (sq),
        .busy     (root_busy),
        .done     (root_done),
        .root     (root_value)
    );

    assign distance = distance_reg;
    assign sum_sqrs = sum_sqrs_reg;

endmodule

// File: doc/dist_unit.md
# dist_unit

Parametrised, handshaked distance engine for the tracking pipeline. It takes two 2-D points and returns one of three distances:
- Euclidean (integer floor square root, computed iteratively)
- Manhattan
- Chebyshev

It sits between the blob/centroid stage and the gesture and geometry logic. It generalises the fixed 11/10-bit Euclidean distance path with configurable coordinate widths, a valid/ready handshake, a selectable metric and deterministic latency.

## Interface
Parameters:
- XW, 11, x coordinate width
- YW, 10, y coordinate width
- derived localparams:
  - MW = max(XW,YW)
  - SW = 2*MW+1 (sum-of-squares width)
  - OW = MW+1 (distance width)

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  request present
- in_ready  out  1  block accepts request this cycle
- x_start, x_end  in  XW  unsigned x coordinates
- y_start, y_end  in  YW  unsigned y coordinates
- mode  in  2  metric: 00 Euclidean, 01 Manhattan, 10 Chebyshev, 11 treated as Euclidean
- out_valid  out  1  result present
- out_ready  in  1  consumer takes result
- distance  out  OW  result
- sum_sqrs  out  SW  dx²+dy² for Euclidean; 0 for the other metrics

## Operation
- FSM states: IDLE, DIFF, SUM, ROOT, DONE.
- Accept: a transfer happens when in_valid && in_ready. Coordinates and mode are latched. Next state is DIFF.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This allows back-to-back requests with no bubble.
- DIFF: compute dx = |x_start−x_end| and dy = |y_start−y_end|, zero-extended to MW bits. No wrap: the subtraction is ordered by comparison.
- SUM:
  - Euclidean: sum = dx²+dy² (SW bits, no overflow possible); go to ROOT.
  - Manhattan: distance = dx+dy (OW bits, exact); go to DONE.
  - Chebyshev: distance = max(dx,dy); go to DONE.
- ROOT: restoring digit-by-digit square root, one result bit per cycle, OW cycles, MSB first. Result = floor(sqrt(sum)). Then go to DONE.
- DONE:
  - out_valid=1; distance and sum_sqrs are held stable until out_ready.
  - On out_ready with no new accept, go to IDLE.
  - On out_ready with a simultaneous accept, go to DIFF.
- Outputs change only on entry to DONE.
- Inputs are ignored outside an accept cycle.
- Reset, including mid-ROOT or mid-DONE: aborts the operation; the in-flight result is discarded.
- Reset values: state=IDLE, in_ready=1, out_valid=0, distance=0, sum_sqrs=0.

## Timing
- Latency is measured from the accept edge to the first cycle with out_valid=1:
  - Euclidean: 2+OW cycles (14 at defaults)
  - Manhattan / Chebyshev: 2 cycles
- Throughput with out_ready held high:
  - Euclidean: one result per 3+OW cycles
  - Manhattan / Chebyshev: one result per 3 cycles
- out_valid stays asserted and the data stays frozen under backpressure for any duration.
- The handshake has no combinational path from in_valid to out_valid. in_ready depends combinationally on out_ready only.

## Configuration
- DIST_ALT_METRIC_EN defined: Manhattan and Chebyshev modes are built.
- DIST_ALT_METRIC_EN undefined:
  - mode is ignored and every request is Euclidean.
  - the adder and max datapaths are removed.
  - latency is always 2+OW.

## Structure
- Package dist_pkg holds:
  - the mode enum: DIST_EUCLID, DIST_MANHATTAN, DIST_CHEBYSHEV
  - the FSM state enum
  - a constant function for max() used in the width derivation
- Sub-module isqrt_seq: parametrised by SW and OW.
  - ports: start, radicand, busy, done, root
  - runs the OW-cycle restoring square root
  - is instantiated once
  - is reusable elsewhere in the codebase.

## Test plan
- Euclidean, defaults: (0,3,0,4) → distance=5, sum_sqrs=25; out_valid exactly 14 cycles after accept.
- Extremes: x 0→2047, y 0→1023.
  - Euclidean → sum_sqrs=5236738, distance=2288.
  - Manhattan → 3070.
  - Chebyshev → 2047.
  - Swapped start/end gives identical results.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid. Required: distance and sum_sqrs stable, in_ready=0, new in_valid not accepted. Release out_ready with in_valid=1: the accept occurs in the same cycle.
- Back-to-back Manhattan stream with out_ready=1: results are 7, 0 and 1023 for (10,3,5,5), (4,4,9,9) and (0,0,0,1023), one every 3 cycles, in order.
- Reset asserted mid-ROOT (cycle 6 of a Euclidean request): the asynchronous clear takes effect immediately. Required: out_valid=0, distance=0, in_ready=1. The next request completes correctly.
- Build without DIST_ALT_METRIC_EN: mode=01 on (0,3,0,4) → distance=5, latency 14.
